fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register. Holds the PC and issues one request
//  at a time to instruction memory. Buffers the returned word and presents it, with its PC,
//  to decode, where the control unit decodes if_id_instr[6:2].
//  Honours the hazard-unit stall and EX-stage redirects from branch, JAL and JALR.
// PARAMETERS
//  XLEN       32            address/data width
//  RESET_PC   32'h0000_0000 first fetch address after reset
//  NOP_INSTR  32'h0000_0013 addi x0,x0,0; bubble loaded into IF/ID
// PORTS
//  clk            in   1     single clock, all state on rising edge
//  rst            in   1     synchronous, active-high reset
//  imem_req       out  1     fetch request; address held stable while high
//  imem_addr      out  XLEN  fetch address, bits [1:0] always 0
//  imem_ack       in   1     request accepted this cycle (req && ack)
//  imem_rvalid    in   1     response valid, at least 1 cycle after ack, one per ack
//  imem_rdata     in   32    instruction word, valid with rvalid
//  stall          in   1     decode cannot accept; IF/ID holds
//  redirect_valid in   1     EX taken branch/JAL/JALR; kill younger work
//  redirect_pc    in   XLEN  new PC; bits [1:0] ignored (forced 0)
//  if_id_valid    out  1     IF/ID holds a live instruction
//  if_id_instr    out  32    instruction to decode/control unit
//  if_id_pc       out  XLEN  PC of if_id_instr
//  if_id_pc4      out  XLEN  if_id_pc + 4 (JAL/JALR link value)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=REQ, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0,
//   if_id_pc4=0, skid buffer empty. Reset mid-transaction: an outstanding response is NOT
//   tracked; the memory is reset on the same rst.
//  imem_req = (state==REQ) && !redirect_valid; imem_addr = {pc[XLEN-1:2],2'b00}.
//  FSM (at most one outstanding request):
//   REQ : redirect -> pc=redirect_pc, stay REQ. Else req&&ack -> WAIT.
//   WAIT: rvalid&&redirect -> drop word, pc=redirect_pc, ->REQ.
//         rvalid&&!stall -> load IF/ID {rdata,pc,pc+4}, valid=1, pc+=4, ->REQ.
//         rvalid&&stall -> capture word and pc in skid buffer, ->HOLD.
//         !rvalid&&redirect -> pc=redirect_pc, ->DRAIN.
//   DRAIN: wait for the stale response; on rvalid discard it, ->REQ.
//          Further redirects here update pc only.
//   HOLD: redirect -> empty buffer, pc=redirect_pc, ->REQ.
//         !stall -> buffer to IF/ID, valid=1, pc+=4, ->REQ.
//  IF/ID update priority per cycle: redirect > stall > new word > bubble.
//   redirect: valid=0, instr=NOP_INSTR (flush, even if stall=1).
//   stall: all IF/ID outputs hold.
//   !stall, no new word this cycle: valid=0, instr=NOP_INSTR; pc fields hold.
//  Latency: ack in cycle N, rvalid in N+k -> IF/ID valid in N+k+1. Peak rate is one
//   instruction per 2 cycles (REQ, WAIT); no prefetch.
//  pc arithmetic: modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0, no flag.
//  rvalid in REQ or HOLD is a protocol error: ignored, no state change.
// STRUCTURE
//  riscv_pkg: fetch_state_t enum {REQ,WAIT,DRAIN,HOLD}, NOP_INSTR, opcode defines shared
//   with the control unit.
//  Sub-module if_id_reg: flush/stall/load register for {valid,instr,pc,pc4}.
//   fetch_stage keeps the FSM, pc and skid buffer.
// TESTING
//  1. rst 2 cycles, mem ack same cycle, 1-cycle rdata -> addr 0,4,8; if_id_pc4 = pc+4,
//     if_id_valid pulses every 2nd cycle, instr matches memory.
//  2. stall=1 over 4 cycles as a word returns -> HOLD, IF/ID frozen. stall=0 -> buffered
//     word appears next cycle; no word lost or duplicated.
//  3. redirect_valid with redirect_pc=0x100 in WAIT, rvalid 3 cycles later -> DRAIN,
//     stale word dropped, next imem_addr=0x100, IF/ID flushed to NOP, valid=0.
//  4. redirect and stall high together -> IF/ID flushed (valid=0, NOP_INSTR), not held.
//  5. rst asserted in HOLD -> next cycle state=REQ, pc=RESET_PC, valid=0.
//  6. redirect_pc=0xFFFF_FFFE -> imem_addr=0xFFFF_FFFC; next sequential fetch wraps to 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, the NOP bubble and the
// opcode[6:2] encodings the control unit decodes from if_id_instr.
package fetch_stage_pkg;

  localparam int          RV_XLEN      = 32;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  // Major opcodes, instr[6:2] (the low two bits are always 2'b11 for RV32I).
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  function automatic logic [4:0] opcode_field(input logic [31:0] instr);
    return instr[6:2];
  endfunction

  function automatic logic is_ctrl_transfer(input logic [31:0] instr);
    logic [4:0] opc;
    opc = opcode_field(instr);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats a new word, and an
// idle non-stalled cycle inserts a bubble while keeping the pc fields.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN      = RV_XLEN,
  parameter logic [31:0]      NOP_INSTR = RV_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [31:0]       instr_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic              valid_o,
  output logic [31:0]       instr_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc4_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic              valid_q;
  logic [31:0]       instr_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc4_q;

  // IF/ID contents, priority flush > stall > load > bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (stall_i) begin
      valid_q <= valid_q;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + PC_STEP;
    end else begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding-request fetch FSM and a
// one-entry skid buffer for a word that returns while decode is stalled.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               XLEN      = RV_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = RV_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_pc4
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;

  logic              load_s;
  logic [31:0]       load_instr_s;
  logic [XLEN-1:0]   load_pc_s;
  logic [XLEN-1:0]   redirect_tgt_s;
  logic [XLEN-1:0]   pc_plus4_s;
  logic [XLEN-1:0]   skid_pc_plus4_s;

  assign redirect_tgt_s  = redirect_pc & ALIGN_MASK;
  assign pc_plus4_s      = pc_q + PC_STEP;
  assign skid_pc_plus4_s = skid_pc_q + PC_STEP;

  // A redirect suppresses the request in the same cycle so a stale address is never accepted.
  assign imem_req  = (state_q == REQ) && !redirect_valid;
  assign imem_addr = {pc_q[XLEN-1:2], 2'b00};

  // Fetch FSM next-state, pc and skid-buffer updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load_s       = 1'b0;
    load_instr_s = skid_instr_q;
    load_pc_s    = skid_pc_q;
    case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_tgt_s;
        end else if (imem_ack) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (imem_rvalid && redirect_valid) begin
          pc_d    = redirect_tgt_s;
          state_d = REQ;
        end else if (imem_rvalid && !stall) begin
          load_s       = 1'b1;
          load_instr_s = imem_rdata;
          load_pc_s    = pc_q;
          pc_d         = pc_plus4_s;
          state_d      = REQ;
        end else if (imem_rvalid) begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = pc_q;
          state_d      = HOLD;
        end else if (redirect_valid) begin
          pc_d    = redirect_tgt_s;
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      DRAIN: begin
        // The killed request's response must still be consumed before issuing again.
        if (redirect_valid) begin
          pc_d = redirect_tgt_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rvalid) begin
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt_s;
          state_d = REQ;
        end else if (!stall) begin
          load_s       = 1'b1;
          load_instr_s = skid_instr_q;
          load_pc_s    = skid_pc_q;
          pc_d         = skid_pc_plus4_s;
          state_d      = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // FSM, pc and skid-buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  fetch_stage_if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .stall_i (stall),
    .load_i  (load_s),
    .instr_i (load_instr_s),
    .pc_i    (load_pc_s),
    .valid_o (if_id_valid),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4)
  );

endmodule
